bbt_ctrl: RTL
=============

# bbt_ctrl

Sequencer for the 64-stage `bbt` bistable-ring PUF. Accepts a 64-bit challenge over a valid/ready handshake and derives RESP_W successive challenges from it with a 64-bit LFSR. For each challenge it pulses the ring reset, waits for the ring to settle, samples `p_bit` VOTES times and majority-votes the samples into one response bit. It returns an RESP_W-bit response over a valid/ready handshake, sitting between the host/key-generation logic and the `bbt` instance.

## Interface
- RST_CYC, 16: cycles `puf_rst` is held high per evaluation (≥1).
- SETTLE_CYC, 256: cycles the ring runs released before sampling (≥3).
- VOTES, 15: evaluations per response bit (odd, ≥1).
- RESP_W, 8: response bits per request (≥1).

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  challenge offered.
- req_ready  out  1  controller idle, will accept.
- req_chal  in  64  seed challenge.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp  out  RESP_W  response; bit i belongs to challenge i.
- resp_unstable  out  RESP_W  per-bit non-unanimous flag (see Configuration).
- puf_chal  out  64  to `bbt.chal`.
- puf_rst  out  1  to `bbt.rst`; 1 holds the ring in reset.
- p_bit  in  1  from `bbt.p_bit`; asynchronous.

## Operation
- `p_bit` passes through a 2-flop synchronizer; only the synchronized value is used.
- States: IDLE, RESET, SETTLE, DECIDE, DONE.
- IDLE: `req_ready`=1, `puf_rst`=1. On `req_valid & req_ready`: chal_reg←req_chal, bit_idx←0, vote_idx←0, ones←0; go to RESET.
- RESET: `puf_rst`=1 for RST_CYC cycles; then go to SETTLE.
- SETTLE: `puf_rst`=0 for SETTLE_CYC cycles. On the last cycle, add the synchronized `p_bit` to ones. If vote_idx==VOTES-1, go to DECIDE; otherwise vote_idx++ and go to RESET.
- DECIDE (1 cycle, `puf_rst`=1):
  - resp[bit_idx] ← (ones > VOTES/2).
  - If bit_idx==RESP_W-1, go to DONE.
  - Otherwise chal_reg ← {chal_reg[62:0], chal_reg[63]^chal_reg[62]^chal_reg[60]^chal_reg[59]}, bit_idx++, vote_idx←0, ones←0, and go to RESET.
- DONE: `resp_valid`=1, `puf_rst`=1; resp held stable. On `resp_ready`, go to IDLE. The response clears only on the next accept.
- `puf_chal` = chal_reg at all times. chal_reg changes only while `puf_rst`=1.
- An all-zero seed stays all-zero through the LFSR. This is legal and is not flagged.
- ones counter width: $clog2(VOTES+1).
- `req_valid` outside IDLE is ignored (`req_ready`=0). There is no abort other than `rst`.

## Timing
- Reset values (async, `rst`=0): state=IDLE, `req_ready`=1, `resp_valid`=0, `resp`=0, `resp_unstable`=0, `puf_rst`=1, `puf_chal`=0, synchronizer=0.
- `rst` asserted mid-operation: the ring is immediately held in reset, the in-flight response is discarded, and the next request is accepted once `rst` deasserts.
- Per evaluation: RST_CYC + SETTLE_CYC cycles.
- Latency from the accept edge to `resp_valid`=1: RESP_W·(VOTES·(RST_CYC+SETTLE_CYC)+1) cycles.
- `resp_valid` and `resp_ready` both high: exactly one cycle of transfer. `req_ready` rises the following cycle, so back-to-back requests are separated by ≥1 idle cycle.
- The sample point is at least SETTLE_CYC-2 cycles after ring release, which covers synchronizer latency.

## Configuration
- `BBT_CTRL_STABILITY_EN` defined:
  - In DECIDE, resp_unstable[bit_idx] ← (ones≠0 && ones≠VOTES).
  - resp_unstable is valid with `resp` in DONE and cleared on accept.
- Undefined: `resp_unstable` is tied to 0, and the comparison logic is not synthesized. The port is present in both builds.

## Test plan
All scenarios use bench parameters RST_CYC=4, SETTLE_CYC=8, VOTES=3, RESP_W=4.
- Reset then idle: `puf_rst`=1, `req_ready`=1, `resp_valid`=0, `resp`=0.
- Ring model with `p_bit`=chal[0] and seed 64'h1: `resp_valid` rises 148 cycles after accept. `puf_chal` sequence is 1, 2, 4, 8; `resp`=4'b0001.
- Ring model outputs 1,0,1 across the votes of bit 0 and constant 0 elsewhere: resp[0]=1. With the macro, resp_unstable=4'b0001; without it, 4'b0000.
- Seed 0 with constant `p_bit`=1: `puf_chal` stays 0 throughout, `resp`=4'hF.
- Hold `resp_ready`=0 for 20 cycles in DONE: `resp` stays stable and `req_ready`=0. Release: `req_ready`=1 one cycle later. A `req_valid` pulse during the busy period is ignored.
- Assert `rst` in the middle of SETTLE of bit 2: outputs return to reset values asynchronously. A new request completes normally.

Source files
------------

// File: rtl/bbt_ctrl.sv
// bbt_ctrl: evaluation sequencer for the 64-stage bbt bistable-ring PUF.
// Takes a seed challenge, walks RESP_W LFSR-derived challenges, and votes
// VOTES ring evaluations into each response bit.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. req_ready is high only in IDLE. resp_valid is high only in
// DONE and holds resp stable until resp_ready is seen.
//
// Optional feature: define BBT_CTRL_STABILITY_EN to flag response bits whose
// votes were not unanimous on resp_unstable. Otherwise that port is tied to 0.
module bbt_ctrl #(
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 256,
    parameter int VOTES      = 15,
    parameter int RESP_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [63:0]       req_chal,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp,
    output logic [RESP_W-1:0] resp_unstable,
    output logic [63:0]       puf_chal,
    output logic              puf_rst,
    input  logic              p_bit
);

    localparam int CNT_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int VOTE_W  = (VOTES > 1) ? $clog2(VOTES) : 1;
    localparam int BIT_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int ONES_W  = $clog2(VOTES + 1);

    localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [VOTE_W-1:0] VOTE_LAST   = VOTE_W'(VOTES - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(RESP_W - 1);
    localparam logic [ONES_W-1:0] HALF        = ONES_W'(VOTES / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_SETTLE,
        S_DECIDE,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VOTE_W-1:0]   vote_q;
    logic [BIT_W-1:0]    bit_q;
    logic [ONES_W-1:0]   ones_q;
    logic [63:0]         chal_q;
    logic [RESP_W-1:0]   resp_q;
    logic                req_ready_q;
    logic                resp_valid_q;
    logic                puf_rst_q;
    logic                sync1_q;
    logic                sync2_q;

    logic [63:0]         chal_d;
    logic [ONES_W-1:0]   ones_d;

    // Next LFSR challenge (taps 63,62,60,59) and vote count including this sample.
    assign chal_d = {chal_q[62:0], chal_q[63] ^ chal_q[62] ^ chal_q[60] ^ chal_q[59]};
    assign ones_d = ones_q + ONES_W'(sync2_q);

    // Two-flop synchronizer for the asynchronous ring output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= p_bit;
            sync2_q <= sync1_q;
        end
    end

    // Sequencer FSM with registered handshake and ring-reset outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vote_q       <= '0;
            bit_q        <= '0;
            ones_q       <= '0;
            chal_q       <= '0;
            resp_q       <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            puf_rst_q    <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        chal_q      <= req_chal;
                        bit_q       <= '0;
                        vote_q      <= '0;
                        ones_q      <= '0;
                        cnt_q       <= '0;
                        resp_q      <= '0;
                        req_ready_q <= 1'b0;
                        state_q     <= S_RESET;
                    end
                end
                S_RESET: begin
                    if (cnt_q == RST_LAST) begin
                        cnt_q     <= '0;
                        puf_rst_q <= 1'b0;
                        state_q   <= S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q     <= '0;
                        ones_q    <= ones_d;
                        puf_rst_q <= 1'b1;
                        if (vote_q == VOTE_LAST) begin
                            state_q <= S_DECIDE;
                        end else begin
                            vote_q  <= vote_q + VOTE_W'(1);
                            state_q <= S_RESET;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DECIDE: begin
                    resp_q[bit_q] <= (ones_q > HALF);
                    if (bit_q == BIT_LAST) begin
                        resp_valid_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        chal_q  <= chal_d;
                        bit_q   <= bit_q + BIT_W'(1);
                        vote_q  <= '0;
                        ones_q  <= '0;
                        state_q <= S_RESET;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef BBT_CTRL_STABILITY_EN
    localparam logic [ONES_W-1:0] ALL_ONES = ONES_W'(VOTES);

    logic [RESP_W-1:0] unstable_q;

    // Mark a response bit whose votes were split; cleared on a new accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            unstable_q <= '0;
        end else if (state_q == S_IDLE && req_valid && req_ready_q) begin
            unstable_q <= '0;
        end else if (state_q == S_DECIDE) begin
            unstable_q[bit_q] <= (ones_q != '0) && (ones_q != ALL_ONES);
        end
    end

    assign resp_unstable = unstable_q;
`else
    assign resp_unstable = '0;
`endif

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp       = resp_q;
    assign puf_chal   = chal_q;
    assign puf_rst    = puf_rst_q;

endmodule
